// File: rtl/multiplication_if.sv
// Operand/result bundle for the fixed-point multiplier.
// master drives operands and receives results; slave is the multiplier side.
interface multiplication_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic [WIDTH-1:0] result;
    logic             overflow;

    modport master (
        output in_valid, a, b,
        input  out_valid, result, overflow
    );

    modport slave (
        input  in_valid, a, b,
        output out_valid, result, overflow
    );
endinterface

// File: rtl/multiplication.sv
// Signed Q(WIDTH-FRAC).FRAC multiplier with optional round-half-up and output saturation.
// Latency: 2 clocks from in_valid sample to out_valid, one result per clock.
// Backpressure: none; result/overflow hold their last valid value across bubbles.
module multiplication #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 8,
    parameter int ROUND = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    multiplication_if.slave  mul_if
);
    localparam int PW = 2 * WIDTH;
    localparam int SW = 2 * WIDTH + 1;

    localparam logic signed [SW-1:0] ONE  = {{(SW-1){1'b0}}, 1'b1};
    localparam logic signed [SW-1:0] RND  = (ROUND != 0) ? (ONE <<< (FRAC - 1)) : '0;
    localparam logic signed [SW-1:0] SMAX = {{(SW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [SW-1:0] SMIN = {{(SW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    logic                    v1_q, v1_d;
    logic signed [PW-1:0]    p_q, p_d;
    logic                    v2_q, v2_d;
    logic        [WIDTH-1:0] res_q, res_d;
    logic                    ov_q, ov_d;

    logic signed [PW-1:0]    a_ext;
    logic signed [PW-1:0]    b_ext;
    logic signed [SW-1:0]    sum;
    logic signed [SW-1:0]    s;

    always_comb begin
        a_ext = {{WIDTH{mul_if.a[WIDTH-1]}}, mul_if.a};
        b_ext = {{WIDTH{mul_if.b[WIDTH-1]}}, mul_if.b};

        // Product only loads on valid beats so idle X operands never reach the pipe.
        v1_d = mul_if.in_valid;
        p_d  = p_q;
        if (mul_if.in_valid) begin
            p_d = a_ext * b_ext;
        end

        // One guard bit above the product keeps the rounding add from wrapping.
        sum = {p_q[PW-1], p_q} + RND;
        s   = sum >>> FRAC;

        v2_d  = v1_q;
        res_d = res_q;
        ov_d  = ov_q;
        if (v1_q) begin
            if (s > SMAX) begin
                res_d = {1'b0, {(WIDTH-1){1'b1}}};
                ov_d  = 1'b1;
            end else if (s < SMIN) begin
                res_d = {1'b1, {(WIDTH-1){1'b0}}};
                ov_d  = 1'b1;
            end else begin
                res_d = s[WIDTH-1:0];
                ov_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_q  <= 1'b0;
            p_q   <= '0;
            v2_q  <= 1'b0;
            res_q <= '0;
            ov_q  <= 1'b0;
        end else begin
            v1_q  <= v1_d;
            p_q   <= p_d;
            v2_q  <= v2_d;
            res_q <= res_d;
            ov_q  <= ov_d;
        end
    end

    assign mul_if.out_valid = v2_q;
    assign mul_if.result    = res_q;
    assign mul_if.overflow  = ov_q;
endmodule

// File: tb/tb_multiplication.sv
// Scoreboarded bench: truncating and rounding multipliers share stimulus, a monitor pops expectations.
module tb_multiplication;
    localparam int W = 16;
    localparam int F = 8;

    typedef struct {
        logic [W-1:0] res;
        logic         ov;
        int           cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    exp_t         q0[$];
    exp_t         q1[$];
    logic [W-1:0] last_res[2] = '{default: '0};
    logic         last_ov[2]  = '{default: 1'b0};

    multiplication_if #(.WIDTH(W)) if0 ();
    multiplication_if #(.WIDTH(W)) if1 ();

    multiplication #(.WIDTH(W), .FRAC(F), .ROUND(0)) dut0 (.clk(clk), .rst_n(rst_n), .mul_if(if0.slave));
    multiplication #(.WIDTH(W), .FRAC(F), .ROUND(1)) dut1 (.clk(clk), .rst_n(rst_n), .mul_if(if1.slave));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Real-number reference: exact product, optional half-LSB bias, floor divide, clamp.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input int rnd, input int c);
        exp_t   e;
        longint p;
        longint s;
        longint maxv;
        longint minv;
        p    = longint'($signed(a)) * longint'($signed(b));
        if (rnd != 0) p = p + (longint'(1) <<< (F - 1));
        s    = p >>> F;
        maxv = (longint'(1) <<< (W - 1)) - 1;
        minv = -(longint'(1) <<< (W - 1));
        e.cyc = c;
        if (s > maxv) begin
            e.res = {1'b0, {(W-1){1'b1}}};
            e.ov  = 1'b1;
        end else if (s < minv) begin
            e.res = {1'b1, {(W-1){1'b0}}};
            e.ov  = 1'b1;
        end else begin
            e.res = s[W-1:0];
            e.ov  = 1'b0;
        end
        return e;
    endfunction

    task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b);
        if0.in_valid = v; if0.a = a; if0.b = b;
        if1.in_valid = v; if1.a = a; if1.b = b;
    endtask

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        drive(1'b1, a, b);
        if (rst_n) begin
            q0.push_back(model(a, b, 0, cyc + 2));
            q1.push_back(model(a, b, 1, cyc + 2));
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, W'($urandom), W'($urandom));
            @(posedge clk); #1;
        end
    endtask

    function automatic logic [W-1:0] rand_op();
        logic [W-1:0] corners[6] = '{16'h8000, 16'h7FFF, 16'h0000, 16'h0001, 16'hFFFF, 16'h0100};
        case ($urandom_range(0, 3))
            0:       return corners[$urandom_range(0, 5)];
            1:       return W'($signed($urandom_range(0, 1023)) - 512);
            default: return W'($urandom);
        endcase
    endfunction

    task automatic mon(input int id, input logic vld, input logic [W-1:0] res, input logic ov);
        exp_t e;
        checks++;
        if (vld) begin
            if ((id == 0 && q0.size() == 0) || (id == 1 && q1.size() == 0)) begin
                errors++;
                $display("FAIL unexpected_beat dut%0d cyc=%0d got res=%h ov=%b, no beat outstanding", id, cyc, res, ov);
            end else begin
                e = (id == 0) ? q0.pop_front() : q1.pop_front();
                if (res !== e.res || ov !== e.ov || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL beat dut%0d got res=%h ov=%b cyc=%0d, expected res=%h ov=%b cyc=%0d",
                             id, res, ov, cyc, e.res, e.ov, e.cyc);
                end
                last_res[id] = e.res;
                last_ov[id]  = e.ov;
            end
        end else if (res !== last_res[id] || ov !== last_ov[id]) begin
            errors++;
            $display("FAIL hold dut%0d cyc=%0d got res=%h ov=%b, expected res=%h ov=%b",
                     id, cyc, res, ov, last_res[id], last_ov[id]);
        end
    endtask

    // A sampled reset drops everything in flight and returns held outputs to zero.
    always @(posedge clk) begin
        if (!rst_n) begin
            q0.delete();
            q1.delete();
            last_res = '{default: '0};
            last_ov  = '{default: 1'b0};
        end
    end

    always @(negedge clk) begin
        if (cyc > 0) begin
            mon(0, if0.out_valid, if0.result, if0.overflow);
            mon(1, if1.out_valid, if1.result, if1.overflow);
        end
    end

    initial begin
        drive(1'b0, '0, '0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);

        // Directed: basic, mixed sign both ways, saturation, rounding corners.
        issue(16'h0180, 16'h0340); idle(3);
        issue(16'h0340, 16'hFE80); idle(1);
        issue(16'hFE80, 16'h0340); idle(2);
        issue(16'h7F80, 16'h0540);
        issue(16'h8000, 16'h0200);
        issue(16'h8000, 16'h8000); idle(2);
        issue(16'h0001, 16'h0001);
        issue(16'hFFFF, 16'h0001);
        issue(16'h0080, 16'h0001);
        issue(16'h007F, 16'h0001);
        issue(16'h0000, 16'h8000); idle(3);

        // Streaming back-to-back.
        issue(16'h0180, 16'h0340);
        issue(16'h0340, 16'hFE80);
        issue(16'h8000, 16'h8000);
        issue(16'h0100, 16'h0100);
        idle(4);

        // Reset with two beats in flight: one in stage 1, one on the inputs.
        issue(16'h0180, 16'h0340);
        rst_n = 1'b0;
        issue(16'h7F80, 16'h0540);
        rst_n = 1'b1;
        idle(5);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            else issue(rand_op(), rand_op());
            if (i == 200) begin
                rst_n = 1'b0;
                idle(1);
                rst_n = 1'b1;
            end
        end
        idle(5);

        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL drain outstanding dut0=%0d dut1=%0d, expected 0 and 0", q0.size(), q1.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
